// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multicycle control FSM for the tinylab CPU datapath
//
// Sequences FETCH -> DECODE -> EXEC/JUMP -> WRITEBACK and drives the PC,
// instruction-fetch, ALU-group and register-file enables. Adds run/halt
// control, a conditional branch (JZ), illegal-opcode trapping and an
// ALU-completion watchdog on top of the basic sequencer.
//
// Optional feature macro: MULTICYCLE_CTRL_PERF_EN (adds retired_cnt).
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous reset, active-high
//   run         in   level; leaves IDLE/HALT toward FETCH
//   alu_end     in   ALU result valid this cycle
//   alu_zero    in   zero flag of last ALU result (sampled in DECODE for JZ)
//   rd          in   destination register field, latched in DECODE
//   opcode      in   opcode, latched in DECODE
//   en_fetch    out  instruction register load
//   en_pc       out  PC update enable
//   en_group    out  ALU operand group enable
//   pc_ctrl     out  01 increment, 10 load jump target, 00 hold
//   reg_en      out  one-hot register write enable
//   alu_in_sel  out  ALU operand B select
//   alu_func    out  ALU operation
//   halted      out  high in HALT
//   illegal     out  high in ERROR, sticky until rst
//   retired_cnt out  retired-instruction counter (perf build only)

module multicycle_ctrl_fsm #(
  parameter int NUM_REGS    = 4,
  parameter int RD_W        = $clog2(NUM_REGS),
  parameter int ALU_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                alu_end,
  input  logic                alu_zero,
  input  logic [RD_W-1:0]     rd,
  input  logic [3:0]          opcode,
  output logic                en_fetch,
  output logic                en_pc,
  output logic                en_group,
  output logic [1:0]          pc_ctrl,
  output logic [NUM_REGS-1:0] reg_en,
  output logic                alu_in_sel,
  output logic [2:0]          alu_func,
  output logic                halted,
  output logic                illegal
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0]         retired_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXEC      = 3'd3,
    S_JUMP      = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6,
    S_ERROR     = 3'd7
  } state_t;

  localparam logic [3:0] OP_MOVEB = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0101;
  localparam logic [3:0] OP_AND   = 4'b0111;
  localparam logic [3:0] OP_OR    = 4'b1001;
  localparam logic [3:0] OP_JUMP  = 4'b1010;
  localparam logic [3:0] OP_JZ    = 4'b1011;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  // Watchdog only ever needs to count 0 .. ALU_TIMEOUT-1.
  localparam int WD_W = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST =
    (ALU_TIMEOUT > 0) ? WD_W'(ALU_TIMEOUT - 1) : '0;

  localparam logic [NUM_REGS-1:0] REG_ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [3:0]      op_q;
  logic [RD_W-1:0] rd_q;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            rd_ok;

  // Non-power-of-two register counts leave rd encodings with no register.
  assign rd_ok = ({{(32-RD_W){1'b0}}, rd} < 32'(NUM_REGS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
        rd_q <= rd;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_MOVEB, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            if (rd_ok) begin
              state_d = S_EXEC;
              wd_d    = '0;
            end else begin
              state_d = S_ERROR;
            end
          end
          OP_JUMP: state_d = S_JUMP;
          OP_JZ:   state_d = alu_zero ? S_JUMP : S_FETCH;
          OP_HALT: state_d = S_HALT;
          default: state_d = S_ERROR;
        endcase
      end
      S_EXEC: begin
        // alu_end wins over a timeout landing on the same cycle.
        if (alu_end) begin
          state_d = S_WRITEBACK;
        end else if (ALU_TIMEOUT != 0) begin
          if (wd_q == WD_LAST) state_d = S_ERROR;
          else                 wd_d    = wd_q + WD_W'(1);
        end
      end
      S_JUMP: begin
        state_d = S_FETCH;
      end
      S_WRITEBACK: begin
        state_d = S_FETCH;
      end
      S_HALT: begin
        if (run) state_d = S_FETCH;
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    en_fetch   = 1'b0;
    en_pc      = 1'b0;
    en_group   = 1'b0;
    pc_ctrl    = 2'b00;
    reg_en     = '0;
    alu_in_sel = 1'b0;
    alu_func   = 3'b000;
    halted     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        en_fetch = 1'b1;
        en_pc    = 1'b1;
        pc_ctrl  = 2'b01;
      end
      S_EXEC: begin
        en_group = 1'b1;
        case (op_q)
          OP_ADD:  alu_func = 3'b001;
          OP_SUB:  alu_func = 3'b010;
          OP_AND:  alu_func = 3'b011;
          OP_OR:   alu_func = 3'b100;
          default: alu_func = 3'b000;
        endcase
        alu_in_sel = (op_q == OP_SUB) || (op_q == OP_AND) || (op_q == OP_OR);
      end
      S_JUMP: begin
        en_pc   = 1'b1;
        pc_ctrl = 2'b10;
      end
      S_WRITEBACK: begin
        reg_en = REG_ONE << rd_q;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      S_ERROR: begin
        illegal = 1'b1;
      end
      default: begin
      end
    endcase
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic retire;

  // An instruction retires when it leaves WRITEBACK or JUMP, or when a
  // not-taken JZ leaves DECODE straight back to FETCH.
  assign retire = (state_q == S_WRITEBACK) || (state_q == S_JUMP) ||
                  ((state_q == S_DECODE) && (opcode == OP_JZ) && !alu_zero);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         retired_cnt <= '0;
    else if (retire) retired_cnt <= retired_cnt + 32'd1;
  end
`endif

endmodule
